// File: rtl/spi_slave_fifo.sv
// SPI slave (any CPOL/CPHA) with RX/TX FIFOs; SPI inputs resynchronised to MClk, RX word reaches Rx_Valid 2 MClk after its last sample edge.
// Full RX FIFO drops words (sticky Rx_Overflow); empty TX FIFO at a load point sends TX_FILL (sticky Tx_Underrun).
module spi_slave_fifo #(
  parameter int                   DATA_BITS   = 8,
  parameter int                   RX_DEPTH    = 16,
  parameter int                   TX_DEPTH    = 16,
  parameter int                   CPOL        = 0,
  parameter int                   CPHA        = 0,
  parameter logic [DATA_BITS-1:0] TX_FILL     = '0,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                             MClk,
  input  logic                             SPI_Rst_Flag,
  input  logic                             SPI_SCLK,
  input  logic                             SPI_CSEL,
  input  logic                             SPI_MOSI,
  output logic                             SPI_MISO,
  output logic                             SPI_MISO_OE,
  output logic [DATA_BITS-1:0]             Rx_Data,
  output logic                             Rx_Valid,
  input  logic                             Rx_Ready,
  input  logic [DATA_BITS-1:0]             Tx_Data,
  input  logic                             Tx_Valid,
  output logic                             Tx_Ready,
  output logic [$clog2(RX_DEPTH+1)-1:0]    Rx_Count,
  output logic [$clog2(TX_DEPTH+1)-1:0]    Tx_Count,
  output logic                             Rx_Overflow,
  output logic                             Tx_Underrun,
  input  logic                             Clear_Status,
  output logic                             Busy,
  output logic                             Frame_Done
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic                   rx_push_q, rx_push_d;
  logic [DATA_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic                   rx_ovf_q, rx_ovf_d;
  logic                   tx_unr_q, tx_unr_d;

  logic [RAW-1:0]         rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RCW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [TAW-1:0]         tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TCW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [DATA_BITS-1:0]   rx_mem_q [RX_DEPTH];
  logic [DATA_BITS-1:0]   tx_mem_q [TX_DEPTH];

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic active, abort, cs_fall, sample_edge, shift_edge, load;
  logic rx_full, rx_empty, rx_pop, rx_push_ok;
  logic tx_full, tx_empty, tx_pop, tx_push;

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s && !sclk_prev_q;
  assign sclk_fall  = !sclk_s && sclk_prev_q;
  assign lead_edge  = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge = (CPOL != 0) ? sclk_rise : sclk_fall;

  // cs_prev_q resets low, so a frame only starts once CSEL has been seen high.
  assign cs_fall     = cs_prev_q && !cs_s;
  assign abort       = busy_q && cs_s;
  assign active      = busy_q && !cs_s;
  assign sample_edge = active && ((CPHA != 0) ? trail_edge : lead_edge);
  assign shift_edge  = active && ((CPHA != 0) ? lead_edge : trail_edge);
  assign load        = (shift_edge && (bit_cnt_q == '0)) || ((CPHA == 0) && cs_fall);

  assign rx_full    = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_pop     = Rx_Ready && !rx_empty;
  assign rx_push_ok = rx_push_q && (!rx_full || rx_pop);
  assign tx_full    = (tx_cnt_q == TCW'(TX_DEPTH));
  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_push    = Tx_Valid && !tx_full;
  assign tx_pop     = load && !tx_empty;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], SPI_CSEL};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    sclk_prev_d  = sclk_s;
    cs_prev_d    = cs_s;
    busy_d       = !cs_s && (busy_q || cs_fall);
    frame_done_d = abort;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    rx_push_d    = 1'b0;

    if (abort) begin
      bit_cnt_d = '0;
      rx_sr_d   = '0;
      tx_sr_d   = '0;
    end else begin
      if (sample_edge) begin
        rx_sr_d = {rx_sr_q[DATA_BITS-2:0], mosi_s};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          rx_push_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      if (load) begin
        tx_sr_d = tx_empty ? TX_FILL : tx_mem_q[tx_rd_ptr_q];
      end else if (shift_edge) begin
        tx_sr_d = {tx_sr_q[DATA_BITS-2:0], 1'b0};
      end
    end

    rx_wr_ptr_d = rx_wr_ptr_q + RAW'(rx_push_ok);
    rx_rd_ptr_d = rx_rd_ptr_q + RAW'(rx_pop);
    rx_cnt_d    = rx_cnt_q + RCW'(rx_push_ok) - RCW'(rx_pop);
    tx_wr_ptr_d = tx_wr_ptr_q + TAW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + TAW'(tx_pop);
    tx_cnt_d    = tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);

    // A set event in the same cycle as Clear_Status wins.
    rx_ovf_d = (rx_push_q && rx_full && !rx_pop) || (rx_ovf_q && !Clear_Status);
    tx_unr_d = (load && tx_empty) || (tx_unr_q && !Clear_Status);
  end

  always_ff @(posedge MClk) begin
    if (SPI_Rst_Flag) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      rx_push_q    <= 1'b0;
      tx_sr_q      <= '0;
      rx_ovf_q     <= 1'b0;
      tx_unr_q     <= 1'b0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_cnt_q     <= '0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_cnt_q     <= '0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      rx_push_q    <= rx_push_d;
      tx_sr_q      <= tx_sr_d;
      rx_ovf_q     <= rx_ovf_d;
      tx_unr_q     <= tx_unr_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_cnt_q     <= tx_cnt_d;
    end
  end

  // rx_sr_q still holds the completed word during the cycle rx_push_q is high.
  always_ff @(posedge MClk) begin
    if (rx_push_ok) rx_mem_q[rx_wr_ptr_q] <= rx_sr_q;
    if (tx_push)    tx_mem_q[tx_wr_ptr_q] <= Tx_Data;
  end

  assign SPI_MISO    = busy_q && tx_sr_q[DATA_BITS-1];
  assign SPI_MISO_OE = busy_q;
  assign Rx_Data     = rx_mem_q[rx_rd_ptr_q];
  assign Rx_Valid    = !rx_empty;
  assign Tx_Ready    = !tx_full;
  assign Rx_Count    = rx_cnt_q;
  assign Tx_Count    = tx_cnt_q;
  assign Rx_Overflow = rx_ovf_q;
  assign Tx_Underrun = tx_unr_q;
  assign Busy        = busy_q;
  assign Frame_Done  = frame_done_q;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one instance per SPI mode (index = CPOL*2+CPHA), RX_DEPTH=4, TX_FILL=0xFF.
// A bit-banged master drives each instance; SCLK runs at MClk/12.
module tb_spi_slave_fifo;

  localparam int HALF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] sclk, csel, mosi, rx_rdy, tx_vld, clr;
  logic [7:0] tx_dat [4];
  logic [3:0] miso, oe, rx_vld, tx_rdy, ovf, unr, busy, fdone;
  logic [7:0] rx_dat [4];
  logic [2:0] rx_cnt [4];
  logic [4:0] tx_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_fifo #(
      .DATA_BITS(8), .RX_DEPTH(4), .TX_DEPTH(16), .CPOL(g / 2), .CPHA(g % 2),
      .TX_FILL(8'hFF), .SYNC_STAGES(2)
    ) dut (
      .MClk(clk), .SPI_Rst_Flag(rst), .SPI_SCLK(sclk[g]), .SPI_CSEL(csel[g]),
      .SPI_MOSI(mosi[g]), .SPI_MISO(miso[g]), .SPI_MISO_OE(oe[g]),
      .Rx_Data(rx_dat[g]), .Rx_Valid(rx_vld[g]), .Rx_Ready(rx_rdy[g]),
      .Tx_Data(tx_dat[g]), .Tx_Valid(tx_vld[g]), .Tx_Ready(tx_rdy[g]),
      .Rx_Count(rx_cnt[g]), .Tx_Count(tx_cnt[g]), .Rx_Overflow(ovf[g]),
      .Tx_Underrun(unr[g]), .Clear_Status(clr[g]), .Busy(busy[g]), .Frame_Done(fdone[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int fd_cnt [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (fdone[i]) fd_cnt[i] <= fd_cnt[i] + 1;
  end

  typedef struct {
    int         mode;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts the top nbits of mo out on MOSI, MSB first; mi collects MISO in the same positions.
  task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (m % 2 == 0) begin
        mosi[m] = mo[i];
        wait_clks(HALF);
        mi[i] = miso[m];
        sclk[m] = ~sclk[m];
        wait_clks(HALF);
        sclk[m] = ~sclk[m];
      end else begin
        sclk[m] = ~sclk[m];
        mosi[m] = mo[i];
        wait_clks(HALF);
        mi[i] = miso[m];
        sclk[m] = ~sclk[m];
        wait_clks(HALF);
      end
    end
  endtask

  task automatic cs_low(input int m);
    csel[m] = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high(input int m);
    wait_clks(HALF);
    csel[m] = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic push_tx(input int m, input logic [7:0] d);
    tx_dat[m] = d;
    tx_vld[m] = 1'b1;
    wait_clks(1);
    tx_vld[m] = 1'b0;
  endtask

  task automatic pop_rx(input int m, input string name, input logic [7:0] exp);
    check({name, "_vld"}, rx_vld[m], 1);
    check(name, rx_dat[m], exp);
    rx_rdy[m] = 1'b1;
    wait_clks(1);
    rx_rdy[m] = 1'b0;
  endtask

  task automatic clear_status(input int m);
    clr[m] = 1'b1;
    wait_clks(1);
    clr[m] = 1'b0;
  endtask

  logic [7:0] mi, mi2;
  int         fd0;

  initial begin
    vecs[0] = '{0, 8'hC3, 8'h81, 8'hC3, 8'h81};
    vecs[1] = '{1, 8'hC3, 8'h81, 8'hC3, 8'h81};
    vecs[2] = '{2, 8'hC3, 8'h81, 8'hC3, 8'h81};
    vecs[3] = '{3, 8'hC3, 8'h81, 8'hC3, 8'h81};
    vecs[4] = '{1, 8'h5A, 8'hE7, 8'h5A, 8'hE7};
    vecs[5] = '{2, 8'h0F, 8'hF0, 8'h0F, 8'hF0};
    vecs[6] = '{3, 8'h01, 8'h80, 8'h01, 8'h80};

    rst = 1'b1;
    csel = 4'hF; mosi = '0; rx_rdy = '0; tx_vld = '0; clr = '0;
    sclk = 4'b1100;
    for (int i = 0; i < 4; i++) tx_dat[i] = '0;
    wait_clks(3);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rst%0d_miso", m), miso[m], 0);
      check($sformatf("rst%0d_oe", m), oe[m], 0);
      check($sformatf("rst%0d_rxvld", m), rx_vld[m], 0);
      check($sformatf("rst%0d_txrdy", m), tx_rdy[m], 1);
      check($sformatf("rst%0d_rxcnt", m), rx_cnt[m], 0);
      check($sformatf("rst%0d_txcnt", m), tx_cnt[m], 0);
      check($sformatf("rst%0d_ovf", m), ovf[m], 0);
      check($sformatf("rst%0d_unr", m), unr[m], 0);
      check($sformatf("rst%0d_busy", m), busy[m], 0);
      check($sformatf("rst%0d_fdone", m), fdone[m], 0);
    end
    rst = 1'b0;
    wait_clks(HALF);

    // Mode 0, two words in one frame.
    push_tx(0, 8'hA5);
    push_tx(0, 8'h3C);
    check("m0_txcnt_pre", tx_cnt[0], 2);
    fd0 = fd_cnt[0];
    cs_low(0);
    check("m0_busy", busy[0], 1);
    check("m0_oe", oe[0], 1);
    xfer(0, 8'h12, 8, mi);
    check("m0_unr_w1", unr[0], 0);
    xfer(0, 8'h34, 8, mi2);
    cs_high(0);
    check("m0_miso_w1", mi, 8'hA5);
    check("m0_miso_w2", mi2, 8'h3C);
    check("m0_fdone_pulses", fd_cnt[0] - fd0, 1);
    check("m0_txcnt_post", tx_cnt[0], 0);
    check("m0_rxcnt", rx_cnt[0], 2);
    pop_rx(0, "m0_rx_w1", 8'h12);
    pop_rx(0, "m0_rx_w2", 8'h34);
    check("m0_rx_empty", rx_vld[0], 0);
    clear_status(0);

    // Single-word frames across all four modes.
    for (int r = 0; r < 7; r++) begin
      int m;
      m = vecs[r].mode;
      push_tx(m, vecs[r].tx);
      fd0 = fd_cnt[m];
      cs_low(m);
      xfer(m, vecs[r].mo, 8, mi);
      cs_high(m);
      check($sformatf("row%0d_miso", r), mi, vecs[r].exp_mi);
      check($sformatf("row%0d_rxcnt", r), rx_cnt[m], 1);
      check($sformatf("row%0d_busy", r), busy[m], 0);
      check($sformatf("row%0d_oe", r), oe[m], 0);
      check($sformatf("row%0d_fdone", r), fd_cnt[m] - fd0, 1);
      pop_rx(m, $sformatf("row%0d_rx", r), vecs[r].exp_rx);
      clear_status(m);
    end

    // Empty TX FIFO: fill word on both words, sticky underrun, then clear.
    check("unr_txcnt_pre", tx_cnt[1], 0);
    cs_low(1);
    xfer(1, 8'h6D, 8, mi);
    xfer(1, 8'h92, 8, mi2);
    cs_high(1);
    check("unr_miso_w1", mi, 8'hFF);
    check("unr_miso_w2", mi2, 8'hFF);
    check("unr_flag", unr[1], 1);
    clear_status(1);
    check("unr_cleared", unr[1], 0);
    pop_rx(1, "unr_rx_w1", 8'h6D);
    pop_rx(1, "unr_rx_w2", 8'h92);

    // RX overflow: five words into a depth-4 FIFO with nothing popped.
    cs_low(0);
    for (int w = 1; w <= 5; w++) xfer(0, 8'(w), 8, mi);
    cs_high(0);
    check("ovf_rxcnt", rx_cnt[0], 4);
    check("ovf_flag", ovf[0], 1);
    for (int w = 1; w <= 4; w++) pop_rx(0, $sformatf("ovf_pop%0d", w), 8'(w));
    check("ovf_empty", rx_vld[0], 0);
    clear_status(0);
    check("ovf_cleared", ovf[0], 0);

    // Frame aborted after 5 bits; the word loaded at CSEL fall stays consumed.
    push_tx(0, 8'h96);
    fd0 = fd_cnt[0];
    cs_low(0);
    xfer(0, 8'hFF, 5, mi);
    cs_high(0);
    check("abort_miso_partial", mi, 8'h90);
    check("abort_rxcnt", rx_cnt[0], 0);
    check("abort_txcnt", tx_cnt[0], 0);
    check("abort_fdone", fd_cnt[0] - fd0, 1);
    check("abort_miso", miso[0], 0);
    check("abort_oe", oe[0], 0);
    push_tx(0, 8'h69);
    cs_low(0);
    xfer(0, 8'hB4, 8, mi);
    cs_high(0);
    check("abort_next_miso", mi, 8'h69);
    pop_rx(0, "abort_next_rx", 8'hB4);
    clear_status(0);

    // Reset pulsed mid-word with CSEL held low.
    cs_low(0);
    xfer(0, 8'hE0, 3, mi);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(1);
    check("midrst_busy", busy[0], 0);
    check("midrst_oe", oe[0], 0);
    check("midrst_miso", miso[0], 0);
    check("midrst_unr", unr[0], 0);
    check("midrst_txrdy", tx_rdy[0], 1);
    xfer(0, 8'h5A, 8, mi);
    check("midrst_ignored_rxcnt", rx_cnt[0], 0);
    check("midrst_ignored_busy", busy[0], 0);
    cs_high(0);
    cs_low(0);
    xfer(0, 8'h5A, 8, mi);
    cs_high(0);
    check("midrst_next_miso", mi, 8'hFF);
    check("midrst_next_rxcnt", rx_cnt[0], 1);
    pop_rx(0, "midrst_next_rx", 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
